// File: rtl/cache_nway_wt.sv
// N-way set-associative write-through cache with a single outstanding request.
// Per-way tag/data/valid storage lives in cache_nway_wt_way; the top holds the FSM, victim choice and counters.

module cache_nway_wt_way #(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 28,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              hit,
  output logic              vld,
  output logic [DATA_W-1:0] rdata
);
  logic [SETS-1:0]             vld_q, vld_d;
  logic [SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [SETS-1:0][DATA_W-1:0] data_q, data_d;

  // A write always targets the set under lookup, so one index serves read and write.
  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (we) begin
      vld_d[idx]  = 1'b1;
      tag_d[idx]  = tag;
      data_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign vld   = vld_q[idx];
  assign hit   = vld_q[idx] && (tag_q[idx] == tag);
  assign rdata = data_q[idx];
endmodule

module cache_nway_wt #(
  parameter int WAYS        = 4,
  parameter int SETS        = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WRITE_ALLOC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;
  logic [31:0]                hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                       resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0]          resp_rdata_q, resp_rdata_d;

  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic [WAYS-1:0]              way_hit, way_vld, way_we;
  logic [WAYS-1:0][DATA_W-1:0]  way_rdata;
  logic [DATA_W-1:0]            hit_data, fill_data;
  logic [WAY_W-1:0]             victim;
  logic                         victim_evict, lookup_hit, fill;

  assign idx = req_q.addr[IDX_W-1:0];
  assign tag = req_q.addr[ADDR_W-1:IDX_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_nway_wt_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_way (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (idx),
      .tag   (tag),
      .we    (way_we[w]),
      .wdata (fill_data),
      .hit   (way_hit[w]),
      .vld   (way_vld[w]),
      .rdata (way_rdata[w])
    );
  end

  assign lookup_hit = |way_hit;

  // Tags are unique within a set, so at most one way contributes.
  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_data = hit_data | way_rdata[w];
  end

  // Lowest invalid way wins; a full set falls back to the round-robin pointer.
  always_comb begin
    victim       = rr_q[idx];
    victim_evict = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_vld[w]) begin
        victim       = WAY_W'(w);
        victim_evict = 1'b0;
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rr_d         = rr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    resp_hit_d   = resp_hit_q;
    resp_rdata_d = resp_rdata_q;
    way_we       = '0;
    fill         = 1'b0;
    fill_data    = req_q.wdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        resp_hit_d = lookup_hit;
        if (lookup_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
        else            miss_cnt_d = sat_inc(miss_cnt_q);
        if (!req_q.wr) begin
          if (lookup_hit) begin
            resp_rdata_d = hit_data;
            state_d      = RESP;
          end else begin
            state_d = MEM_RD;
          end
        end else begin
          if (lookup_hit)              way_we = way_hit;
          else if (WRITE_ALLOC != 0)   fill   = 1'b1;
          state_d = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          fill         = 1'b1;
          fill_data    = mem_rdata;
          resp_rdata_d = mem_rdata;
          state_d      = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fill) begin
      way_we[victim] = 1'b1;
      if (victim_evict) rr_d[idx] = rr_q[idx] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      rr_q         <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rr_q         <= rr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory-side fields come straight from the latched request, so they hold while mem_req is up.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_wr     = (state_q == MEM_WR);
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_cache_nway_wt.sv
// Directed + random bench for cache_nway_wt against a set/way reference model and a memory responder.
module tb_cache_nway_wt;
  localparam int WAYS = 4, SETS = 16, AW = 32, DW = 32;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_hit, mem_req, mem_wr;
  logic [DW-1:0] resp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   hit_cnt, miss_cnt;

  cache_nway_wt #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(AW), .DATA_W(DW), .WRITE_ALLOC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_rdata(resp_rdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  // Second instance without write-allocate; its memory acks immediately.
  logic          n_req_valid = 1'b0, n_req_wr = 1'b0;
  logic [AW-1:0] n_req_addr = '0;
  logic [DW-1:0] n_req_wdata = '0;
  logic          n_req_ready, n_resp_valid, n_resp_hit, n_mem_req, n_mem_wr, n_mem_ack;
  logic [DW-1:0] n_resp_rdata, n_mem_wdata, n_mem_rdata;
  logic [AW-1:0] n_mem_addr;
  logic [31:0]   n_hit_cnt, n_miss_cnt;
  assign n_mem_ack   = n_mem_req;
  assign n_mem_rdata = 32'hC0DE_0000;

  cache_nway_wt #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(AW), .DATA_W(DW), .WRITE_ALLOC(0)) dut_na (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_wr(n_req_wr),
    .req_addr(n_req_addr), .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_hit(n_resp_hit),
    .resp_rdata(n_resp_rdata), .mem_req(n_mem_req), .mem_wr(n_mem_wr), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_ack(n_mem_ack), .mem_rdata(n_mem_rdata),
    .hit_cnt(n_hit_cnt), .miss_cnt(n_miss_cnt));

  int errors = 0, checks = 0;

  // Memory environment: backing store plus an ack-delay responder.
  logic [31:0] tbmem [logic [31:0]];
  int ack_dly = 0, acnt = 0, memreq_cyc = 0, memwr_cnt = 0;
  logic [31:0] last_mwdata = '0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return tbmem.exists(a) ? tbmem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      acnt    = 0;
    end else begin
      memreq_cyc++;
      if (acnt >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = memval(mem_addr);
        if (mem_wr) begin
          tbmem[mem_addr] = mem_wdata;
          memwr_cnt++;
          last_mwdata = mem_wdata;
        end
      end else begin
        mem_ack = 1'b0;
        acnt++;
      end
    end
  end

  // Reference model: plain per-set way table with round-robin pointer.
  bit          mv [SETS][WAYS];
  logic [31:0] mt [SETS][WAYS];
  logic [31:0] md [SETS][WAYS];
  int          rr [SETS];
  logic [31:0] m_hits = 0, m_miss = 0;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      rr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              output bit h, output logic [31:0] rd);
    int s, hw, v;
    logic [31:0] t;
    s = int'(a % SETS);
    t = a / SETS;
    hw = -1;
    v = -1;
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
    h  = (hw >= 0);
    rd = memval(a);
    if (h) begin
      m_hits = sat(m_hits);
      rd = md[s][hw];
      if (wr) md[s][hw] = wd;
    end else begin
      m_miss = sat(m_miss);
      if (!wr || 1) begin
        for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
        if (v < 0) begin
          v = rr[s];
          rr[s] = (rr[s] + 1) % WAYS;
        end
        mv[s][v] = 1'b1;
        mt[s][v] = t;
        md[s][v] = wr ? wd : memval(a);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd, input int dly,
                        input bit hold, output bit oh, output logic [31:0] ord, output int lat);
    bit eh, got;
    logic [31:0] ed;
    int mreq0, mwr0, elat;
    model_access(wr, a, wd, eh, ed);
    elat = (eh && !wr) ? 2 : 3 + dly;
    ack_dly = dly;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    mreq0 = memreq_cyc;
    mwr0  = memwr_cnt;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    @(posedge clk);
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
      else if (hold) begin
        req_addr = $urandom; req_wr = 1'($urandom); req_wdata = $urandom;
      end else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    oh  = resp_hit;
    ord = resp_rdata;
    chk("resp_seen", got, 1);
    chk("latency", lat, elat);
    chk("resp_hit", resp_hit, eh);
    if (!wr) chk("rdata", resp_rdata, ed);
    chk("mem_writes", memwr_cnt - mwr0, wr);
    if (wr) chk("mem_wdata", last_mwdata, wd);
    if (eh && !wr) chk("hit_no_memreq", memreq_cyc - mreq0, 0);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic n_req(input bit wr, input logic [31:0] a, output bit h);
    int k;
    k = 0;
    @(negedge clk);
    n_req_valid = 1'b1; n_req_wr = wr; n_req_addr = a; n_req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    n_req_valid = 1'b0;
    while (!n_resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("na_resp_seen", n_resp_valid, 1);
    h = n_resp_hit;
  endtask

  bit          h;
  logic [31:0] d;
  int          l, k;
  bit          rw;
  logic [31:0] ra;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic miss then hit
    tbmem[32'h10] = 32'hAAAA_0001;
    do_req(0, 32'h10, 0, 2, 0, h, d, l);
    chk("t1_miss", h, 0);
    chk("t1_rdata", d, 32'hAAAA_0001);
    chk("t1_lat", l, 5);
    chk("t1_miss_cnt", miss_cnt, 1);
    do_req(0, 32'h10, 0, 0, 0, h, d, l);
    chk("t1_hit", h, 1);
    chk("t1_hit_lat", l, 2);
    chk("t1_hit_cnt", hit_cnt, 1);

    // Set 3 overflow: fifth fill evicts way0
    for (int i = 0; i < 5; i++) do_req(0, 32'h03 + 32'(i) * 32'h10, 0, 0, 0, h, d, l);
    do_req(0, 32'h13, 0, 1, 0, h, d, l);
    chk("t2_13_hit", h, 1);
    do_req(0, 32'h03, 0, 1, 0, h, d, l);
    chk("t2_03_miss", h, 0);

    // Write miss allocates; write hit goes through once
    do_req(1, 32'h05, 32'h1234, 1, 0, h, d, l);
    chk("t3_wr_miss", h, 0);
    do_req(0, 32'h05, 0, 0, 0, h, d, l);
    chk("t3_rd_hit", h, 1);
    chk("t3_rd_data", d, 32'h1234);
    n_req(1, 32'h05, h);
    chk("na_wr_miss", h, 0);
    n_req(0, 32'h05, h);
    chk("na_rd_miss", h, 0);
    n_req(0, 32'h05, h);
    chk("na_rd_hit", h, 1);
    chk("na_miss_cnt", n_miss_cnt, 2);
    do_req(1, 32'h05, 32'h5678, 2, 0, h, d, l);
    chk("t4_wr_hit", h, 1);
    do_req(0, 32'h05, 0, 0, 0, h, d, l);
    chk("t4_rd_data", d, 32'h5678);

    // Request held/toggled while busy; saturating miss counter
    do_req(0, 32'h77, 0, 2, 1, h, d, l);
    do_req(0, 32'h77, 0, 0, 0, h, d, l);
    chk("t6_latched_hit", h, 1);
    @(negedge clk);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.miss_cnt_q;
    m_miss = 32'hFFFF_FFFF;
    do_req(0, 32'h88, 0, 0, 0, h, d, l);
    chk("t6_miss_sat", miss_cnt, 32'hFFFF_FFFF);

    // Reset during MEM_RD
    ack_dly = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h27;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_mem_req_up", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req_drop", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_resp", resp_valid, 0);
    end
    chk("t5_miss_cnt", miss_cnt, 0);
    chk("t5_ready", req_ready, 1);
    rst_n = 1'b1;
    model_reset();
    do_req(0, 32'h27, 0, 0, 0, h, d, l);
    chk("t5_post_miss", h, 0);

    // Random traffic over a few tags per set
    for (int i = 0; i < 80; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
      do_req(rw, ra, $urandom, $urandom_range(0, 3), 0, h, d, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
